// File: rtl/jk_toggle_monitor_pkg.sv
// Shared definitions for the JK toggle monitor.
// Holds the two-state window FSM encoding and the default parameter values used by
// jk_toggle_monitor and its sub-module.
package jk_toggle_monitor_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StCount = 1'b1
  } jkmon_state_e;

  localparam int unsigned DefWindow      = 16;
  localparam int unsigned DefCntW        = 8;
  localparam int unsigned DefStuckCycles = 64;

endpackage

// File: rtl/jk_toggle_monitor_q_edge_det.sv
// Edge detector for the Q output of an upstream JK flop in the same clock domain.
// Ports:
//   clk1       in  system clock, rising edge
//   s_reset    in  synchronous reset, active-high
//   q_in       in  Q of the upstream flop
//   q_edge_o   out combinational: q_in differs from last cycle's sample
//   rise_o     out registered 1-cycle pulse after a 0->1 edge is sampled
//   fall_o     out registered 1-cycle pulse after a 1->0 edge is sampled
module jk_toggle_monitor_q_edge_det (
  input  logic clk1,
  input  logic s_reset,
  input  logic q_in,
  output logic q_edge_o,
  output logic rise_o,
  output logic fall_o
);

  logic q_s_q;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    q_edge_o = q_in ^ q_s_q;
    rise_d   = q_in & ~q_s_q;
    fall_d   = ~q_in & q_s_q;
  end

  always_ff @(posedge clk1) begin
    if (s_reset) begin
      q_s_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      q_s_q  <= q_in;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/jk_toggle_monitor.sv
// JK toggle monitor: counts edges of a JK flop's Q over back-to-back windows of WINDOW
// cycles and hands each window's (saturating) count out through a valid/ready register.
// Optional feature macro: JKMON_STUCK_DETECT_EN enables the stuck (no-edge) detector;
// without it, stuck is tied to 0.
// Ports:
//   clk1        in  system clock, rising edge
//   s_reset     in  synchronous reset, active-high
//   q_in        in  Q of the upstream JK flop
//   enable      in  1 = windows run, 0 = idle (partial window discarded)
//   rise_pulse  out pulse after a 0->1 edge of q_in
//   fall_pulse  out pulse after a 1->0 edge of q_in
//   cnt_data    out toggle count of the last reported window
//   cnt_valid   out cnt_data is unconsumed
//   cnt_ready   in  consumer accepts on cnt_valid & cnt_ready
//   overrun     out sticky: a window result was dropped
//   stuck       out q_in unchanged for STUCK_CYCLES cycles
module jk_toggle_monitor
  import jk_toggle_monitor_pkg::*;
#(
  parameter int unsigned WINDOW       = DefWindow,
  parameter int unsigned CNT_W        = DefCntW,
  parameter int unsigned STUCK_CYCLES = DefStuckCycles
) (
  input  logic             clk1,
  input  logic             s_reset,
  input  logic             q_in,
  input  logic             enable,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             overrun,
  output logic             stuck
);

  localparam int unsigned WinW = $clog2(WINDOW);
  localparam logic [WinW-1:0]  WinLast = WinW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  jkmon_state_e     state_q, state_d;
  logic [WinW-1:0]  win_q, win_d, win_base;
  logic [CNT_W-1:0] tog_q, tog_d, tog_base, tog_next;
  logic [CNT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             q_edge;
  logic             counting, close;

  jk_toggle_monitor_q_edge_det u_edge_det (
    .clk1     (clk1),
    .s_reset  (s_reset),
    .q_in     (q_in),
    .q_edge_o (q_edge),
    .rise_o   (rise_pulse),
    .fall_o   (fall_pulse)
  );

  // Window FSM and counters. The cycle IDLE sees enable=1 is already window cycle 0,
  // so counting starts from zero bases there instead of the held registers.
  always_comb begin
    state_d  = state_q;
    win_d    = '0;
    tog_d    = '0;
    win_base = (state_q == StCount) ? win_q : '0;
    tog_base = (state_q == StCount) ? tog_q : '0;
    tog_next = (tog_base == CntMax) ? CntMax : tog_base + CNT_W'(q_edge);
    close    = (state_q == StCount) && (win_q == WinLast);

    unique case (state_q)
      StIdle:  state_d = enable ? StCount : StIdle;
      StCount: state_d = enable ? StCount : StIdle;
      default: state_d = StIdle;
    endcase

    // A closing cycle completes its window even if enable drops in that same cycle.
    counting = ((state_q == StIdle) && enable) || ((state_q == StCount) && (enable || close));
    if (counting && !close) begin
      win_d = win_base + 1'b1;
      tog_d = tog_next;
    end
  end

  // Result hand-off: a new result may replace a pending one only when it is accepted now.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (close) begin
      if (!valid_q || cnt_ready) begin
        data_d  = tog_next;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && cnt_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk1) begin
    if (s_reset) begin
      state_q <= StIdle;
      win_q   <= '0;
      tog_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      tog_q   <= tog_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign cnt_data  = data_q;
  assign cnt_valid = valid_q;
  assign overrun   = ovr_q;

`ifdef JKMON_STUCK_DETECT_EN
  localparam int unsigned StuckW = $clog2(STUCK_CYCLES + 1);
  localparam logic [StuckW-1:0] StuckMax = StuckW'(STUCK_CYCLES);

  logic [StuckW-1:0] idle_q, idle_d;

  // Saturating count of edge-free cycles; independent of enable.
  always_comb begin
    idle_d = idle_q;
    if (q_edge) begin
      idle_d = '0;
    end else if (idle_q != StuckMax) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk1) begin
    if (s_reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

  assign stuck = (idle_q == StuckMax);
`else
  logic unused_stuck_cycles;
  assign unused_stuck_cycles = ^STUCK_CYCLES;
  assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_jk_toggle_monitor.sv
// Self-checking bench for jk_toggle_monitor with WINDOW=4, CNT_W=2, STUCK_CYCLES=8.
// Directed scenarios with literal expectations, then randomized stimulus, all checked every
// cycle against a window-level behavioural model.
module tb_jk_toggle_monitor;

  localparam int W  = 4;
  localparam int CW = 2;
  localparam int SC = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk1;
  logic          s_reset;
  logic          q_in;
  logic          enable;
  logic          cnt_ready;
  logic          rise_pulse;
  logic          fall_pulse;
  logic [CW-1:0] cnt_data;
  logic          cnt_valid;
  logic          overrun;
  logic          stuck;

  int n_checks = 0;
  int n_fail   = 0;

  jk_toggle_monitor #(
    .WINDOW       (W),
    .CNT_W        (CW),
    .STUCK_CYCLES (SC)
  ) dut (
    .clk1       (clk1),
    .s_reset    (s_reset),
    .q_in       (q_in),
    .enable     (enable),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .cnt_data   (cnt_data),
    .cnt_valid  (cnt_valid),
    .cnt_ready  (cnt_ready),
    .overrun    (overrun),
    .stuck      (stuck)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: window position/count plus the reported result register.
  bit m_q_prev, m_active, m_valid, m_ovr, m_rise, m_fall;
  int m_pos, m_cnt, m_data, m_idle;

  always begin
    bit e, close, acc;
    int result;
    @(posedge clk1);
    if (s_reset) begin
      m_q_prev = 0; m_active = 0; m_valid = 0; m_ovr = 0; m_rise = 0; m_fall = 0;
      m_pos = 0; m_cnt = 0; m_data = 0; m_idle = 0;
    end else begin
      e      = (q_in != m_q_prev);
      close  = 0;
      result = 0;
      m_rise = q_in && !m_q_prev;
      m_fall = !q_in && m_q_prev;
      if (m_active && m_pos != W - 1 && !enable) begin
        m_active = 0; m_pos = 0; m_cnt = 0;
      end else if (m_active || enable) begin
        if (!m_active) begin
          m_active = 1; m_pos = 0; m_cnt = 0;
        end
        m_cnt = (m_cnt + e > CMAX) ? CMAX : m_cnt + e;
        if (m_pos == W - 1) begin
          close = 1; result = m_cnt;
          m_pos = 0; m_cnt = 0; m_active = enable;
        end else begin
          m_pos++;
        end
      end
      acc = m_valid && cnt_ready;
      if (close) begin
        if (!m_valid || cnt_ready) begin
          m_data = result; m_valid = 1;
        end else begin
          m_ovr = 1;
        end
      end else if (acc) begin
        m_valid = 0;
      end
      m_idle   = e ? 0 : ((m_idle + 1 > SC) ? SC : m_idle + 1);
      m_q_prev = q_in;
    end
    #1;
    chk("rise_pulse", int'(rise_pulse), int'(m_rise));
    chk("fall_pulse", int'(fall_pulse), int'(m_fall));
    chk("cnt_data",   int'(cnt_data),   m_data);
    chk("cnt_valid",  int'(cnt_valid),  int'(m_valid));
    chk("overrun",    int'(overrun),    int'(m_ovr));
`ifdef JKMON_STUCK_DETECT_EN
    chk("stuck", int'(stuck), int'(m_idle == SC));
`else
    chk("stuck", int'(stuck), 0);
`endif
  end

  // Apply inputs on a falling edge, return on the next falling edge.
  task automatic drive(input bit rst, input bit en, input bit q, input bit rdy);
    s_reset = rst; enable = en; q_in = q; cnt_ready = rdy;
    @(negedge clk1);
  endtask

  initial begin
    s_reset = 1'b1; enable = 1'b0; q_in = 1'b0; cnt_ready = 1'b0;
    @(negedge clk1);
    drive(1, 0, 0, 0);
    chk("reset_valid", int'(cnt_valid), 0);
    chk("reset_data", int'(cnt_data), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_pulses", int'(rise_pulse | fall_pulse), 0);

    // 1: flat Q, two windows of 0
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 1);
    chk("s1_valid_w1", int'(cnt_valid), 1);
    chk("s1_data_w1", int'(cnt_data), 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 1);
    chk("s1_valid_w2", int'(cnt_valid), 1);
    chk("s1_overrun", int'(overrun), 0);

    // 2: toggle every cycle, count saturates at 3
    drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, (i % 2) == 0, 1);
    chk("s2_data_sat", int'(cnt_data), 3);
    chk("s2_fall_last", int'(fall_pulse), 1);
    chk("s2_rise_last", int'(rise_pulse), 0);

    // 3: single edge in the last window cycle, then a flat window
    drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, i == 3, 1);
    chk("s3_data_one", int'(cnt_data), 1);
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 1);
    chk("s3_data_zero", int'(cnt_data), 0);

    // 4: consumer stalls over 3 windows
    drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, i == 3, 0);
    chk("s4_overrun_w1", int'(overrun), 0);
    for (int i = 0; i < 8; i++) drive(0, 1, 1, 0);
    chk("s4_overrun_w3", int'(overrun), 1);
    chk("s4_data_held", int'(cnt_data), 1);
    drive(0, 0, 1, 1);
    chk("s4_valid_acc", int'(cnt_valid), 0);
    chk("s4_data_after", int'(cnt_data), 1);

    // 5: enable dropped mid-window after 2 edges, then a fresh window
    drive(1, 0, 0, 0);
    drive(0, 1, 1, 1);
    drive(0, 1, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1);
    chk("s5_no_result", int'(cnt_valid), 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 1);
    chk("s5_fresh_valid", int'(cnt_valid), 1);
    chk("s5_fresh_data", int'(cnt_data), 0);

    // 6: reset mid-window with a pending result
    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, (i % 2) == 0, 0);
    chk("s6_pending", int'(cnt_valid), 1);
    drive(1, 1, 1, 0);
    chk("s6_rst_valid", int'(cnt_valid), 0);
    chk("s6_rst_data", int'(cnt_data), 0);

`ifdef JKMON_STUCK_DETECT_EN
    drive(1, 0, 0, 0);
    for (int i = 0; i < SC; i++) drive(0, 0, 0, 0);
    chk("stuck_set", int'(stuck), 1);
    drive(0, 0, 1, 0);
    chk("stuck_clr", int'(stuck), 0);
`endif

    // Randomized stimulus
    drive(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit rst, en, q, rdy;
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 15) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      q   = (($urandom_range(0, 2) == 0)) ? ~q_in : q_in;
      drive(rst, en, q, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
